// File: rtl/ace_ram_arbiter.sv
// Three-way arbiter for the ace single-port main RAM: video > loader > CPU,
// with a CPU starvation guard. Define ARB_PERF_EN to add stall counters.
module ace_ram_arbiter #(
  parameter int AW         = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
`ifdef ARB_PERF_EN
  input  logic          perf_clr,
  output logic [15:0]   cpu_stall_cnt,
  output logic [15:0]   ldr_stall_cnt,
`endif
  input  logic          video_req,
  input  logic [AW-1:0] video_addr,
  output logic          video_ack,
  output logic [7:0]    video_data,
  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_addr,
  input  logic [7:0]    ldr_din,
  output logic          ldr_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_wait,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout
);

  typedef enum logic {
    SRC_VIDEO = 1'b0,
    SRC_CPU   = 1'b1
  } rd_src_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]    r_starve_cnt;
  logic          r_rd_pend;
  rd_src_e       r_rd_src;
  logic          r_cpu_busy;
  logic [7:0]    r_video_data;
  logic [7:0]    r_cpu_dout;
  logic [AW-1:0] r_ram_addr;
  logic [7:0]    r_ram_din;

  logic          w_cpu_elig;
  logic          w_cpu_pri;
  logic          w_vid_gnt;
  logic          w_ldr_gnt;
  logic          w_cpu_gnt;
  logic          w_cap_vid;
  logic          w_cap_cpu;

  // The CPU may not re-enter while its own read is still in the capture stage.
  assign w_cpu_elig = cpu_req & ~r_cpu_busy;
  assign w_cpu_pri  = (r_starve_cnt >= STARVE_LIM);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else chain can leave a signal unassigned (latch).
  always_comb begin
    w_vid_gnt = 1'b0;
    w_ldr_gnt = 1'b0;
    w_cpu_gnt = 1'b0;
    if (!reset) begin
      if (video_req)                    w_vid_gnt = 1'b1;
      else if (w_cpu_pri && w_cpu_elig) w_cpu_gnt = 1'b1;
      else if (ldr_req)                 w_ldr_gnt = 1'b1;
      else if (w_cpu_elig)              w_cpu_gnt = 1'b1;
    end
  end

  always_comb begin
    ram_addr = r_ram_addr;
    ram_din  = r_ram_din;
    ram_we   = 1'b0;
    if (w_vid_gnt) begin
      ram_addr = video_addr;
    end else if (w_ldr_gnt) begin
      ram_addr = ldr_addr;
      ram_din  = ldr_din;
      ram_we   = 1'b1;
    end else if (w_cpu_gnt) begin
      ram_addr = cpu_addr;
      if (cpu_we) begin
        ram_din = cpu_din;
        ram_we  = 1'b1;
      end
    end
  end

  // Capture is suppressed while reset is asserted so an in-flight read is dropped.
  assign w_cap_vid = r_rd_pend & (r_rd_src == SRC_VIDEO) & ~reset;
  assign w_cap_cpu = r_rd_pend & (r_rd_src == SRC_CPU)   & ~reset;

  assign video_ack  = w_cap_vid;
  assign video_data = w_cap_vid ? ram_dout : r_video_data;
  assign cpu_dout   = w_cap_cpu ? ram_dout : r_cpu_dout;
  assign ldr_ack    = w_ldr_gnt;
  assign cpu_wait   = cpu_req & ~(w_cpu_gnt & cpu_we) & ~w_cap_cpu;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_src     <= SRC_VIDEO;
      r_cpu_busy   <= 1'b0;
      r_video_data <= '0;
      r_cpu_dout   <= '0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
    end else begin
      r_rd_pend  <= w_vid_gnt | (w_cpu_gnt & ~cpu_we);
      r_rd_src   <= w_vid_gnt ? SRC_VIDEO : SRC_CPU;
      r_cpu_busy <= w_cpu_gnt & ~cpu_we;
      r_ram_addr <= ram_addr;
      r_ram_din  <= ram_din;
      if (w_cap_vid) r_video_data <= ram_dout;
      if (w_cap_cpu) r_cpu_dout   <= ram_dout;
      if (cpu_req && !w_cpu_gnt) begin
        if (r_starve_cnt != 8'hFF) r_starve_cnt <= r_starve_cnt + 8'd1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

`ifdef ARB_PERF_EN
  logic [15:0] r_cpu_stall;
  logic [15:0] r_ldr_stall;

  always_ff @(posedge clk_sys) begin
    if (reset || perf_clr) begin
      r_cpu_stall <= '0;
      r_ldr_stall <= '0;
    end else begin
      if (cpu_req && !w_cpu_gnt && (r_cpu_stall != 16'hFFFF))
        r_cpu_stall <= r_cpu_stall + 16'd1;
      if (ldr_req && !w_ldr_gnt && (r_ldr_stall != 16'hFFFF))
        r_ldr_stall <= r_ldr_stall + 16'd1;
    end
  end

  assign cpu_stall_cnt = r_cpu_stall;
  assign ldr_stall_cnt = r_ldr_stall;
`endif

endmodule

// File: tb/tb_ace_ram_arbiter.sv
// Bench for ace_ram_arbiter: per-cycle vector table, read-data scoreboards and
// hand sequences for starvation, reset-mid-read and (ARB_PERF_EN) stall counters.
module tb_ace_ram_arbiter;

  logic        clk_sys;
  logic        reset;
  logic        video_req;
  logic [15:0] video_addr;
  logic        video_ack;
  logic [7:0]  video_data;
  logic        ldr_req;
  logic [15:0] ldr_addr;
  logic [7:0]  ldr_din;
  logic        ldr_ack;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_wait;
  logic [7:0]  cpu_dout;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
`ifdef ARB_PERF_EN
  logic        perf_clr;
  logic [15:0] cpu_stall_cnt;
  logic [15:0] ldr_stall_cnt;
`endif

  ace_ram_arbiter #(.AW(16), .STARVE_MAX(8)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
`ifdef ARB_PERF_EN
    .perf_clr      (perf_clr),
    .cpu_stall_cnt (cpu_stall_cnt),
    .ldr_stall_cnt (ldr_stall_cnt),
`endif
    .video_req  (video_req),
    .video_addr (video_addr),
    .video_ack  (video_ack),
    .video_data (video_data),
    .ldr_req    (ldr_req),
    .ldr_addr   (ldr_addr),
    .ldr_din    (ldr_din),
    .ldr_ack    (ldr_ack),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_wait   (cpu_wait),
    .cpu_dout   (cpu_dout),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Single-port RAM, 1-cycle read latency; known contents loaded during reset.
  logic [7:0] mem [0:65535];
  always @(posedge clk_sys) begin
    if (reset) begin
      mem[16'h2400] <= 8'h11;
      mem[16'h2401] <= 8'h22;
      mem[16'h3C00] <= 8'h5A;
      mem[16'h1234] <= 8'h77;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  int unsigned cyc_n = 0;
  always @(posedge clk_sys) cyc_n <= cyc_n + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
  } exp_t;

  exp_t vid_q[$];
  exp_t cpu_q[$];
  bit   vid_mon_en = 1'b1;

  always @(negedge clk_sys) begin
    exp_t e;
    if (vid_mon_en && video_ack) begin
      if (vid_q.size() == 0) begin
        check("video_ack unexpected", {31'd0, video_ack}, 32'd0);
      end else begin
        e = vid_q.pop_front();
        check("video_data", {24'd0, video_data}, {24'd0, e.data});
        check("video_ack cycle", cyc_n, e.cyc);
      end
    end
    if (!reset && cpu_req && !cpu_we && !cpu_wait) begin
      if (cpu_q.size() == 0) begin
        check("cpu read unexpected", {31'd0, cpu_wait}, 32'd1);
      end else begin
        e = cpu_q.pop_front();
        check("cpu_dout", {24'd0, cpu_dout}, {24'd0, e.data});
        check("cpu done cycle", cyc_n, e.cyc);
      end
    end
  end

  typedef struct {
    string       name;
    logic        vreq;
    logic [15:0] vaddr;
    logic [7:0]  vexp;
    logic        lreq;
    logic [15:0] laddr;
    logic [7:0]  ldin;
    logic        creq;
    logic        cwe;
    logic [15:0] caddr;
    logic [7:0]  cdin;
    logic        e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_din;
    logic        e_lack;
    logic        e_wait;
  } vec_t;

  vec_t vecs[17];

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ldr_idx;

    vecs[0]  = '{"ldr w0",     0, 16'h0000, 8'h00, 1, 16'h2000, 8'hA0, 0, 0, 16'h0000, 8'h00, 1, 16'h2000, 8'hA0, 1, 0};
    vecs[1]  = '{"ldr w1",     0, 16'h0000, 8'h00, 1, 16'h2001, 8'hA1, 0, 0, 16'h0000, 8'h00, 1, 16'h2001, 8'hA1, 1, 0};
    vecs[2]  = '{"ldr w2",     0, 16'h0000, 8'h00, 1, 16'h2002, 8'hA2, 0, 0, 16'h0000, 8'h00, 1, 16'h2002, 8'hA2, 1, 0};
    vecs[3]  = '{"ldr w3",     0, 16'h0000, 8'h00, 1, 16'h2003, 8'hA3, 0, 0, 16'h0000, 8'h00, 1, 16'h2003, 8'hA3, 1, 0};
    vecs[4]  = '{"all3 video", 1, 16'h1234, 8'h77, 1, 16'h2100, 8'hB1, 1, 1, 16'h2200, 8'hC2, 0, 16'h1234, 8'h00, 0, 1};
    vecs[5]  = '{"all3 ldr",   0, 16'h0000, 8'h00, 1, 16'h2100, 8'hB1, 1, 1, 16'h2200, 8'hC2, 1, 16'h2100, 8'hB1, 1, 1};
    vecs[6]  = '{"all3 cpu",   0, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 1, 1, 16'h2200, 8'hC2, 1, 16'h2200, 8'hC2, 0, 0};
    vecs[7]  = '{"idle hold",  0, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 16'h2200, 8'h00, 0, 0};
    vecs[8]  = '{"rb 2000",    1, 16'h2000, 8'hA0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 16'h2000, 8'h00, 0, 0};
    vecs[9]  = '{"rb 2001",    1, 16'h2001, 8'hA1, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 16'h2001, 8'h00, 0, 0};
    vecs[10] = '{"rb 2002",    1, 16'h2002, 8'hA2, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 16'h2002, 8'h00, 0, 0};
    vecs[11] = '{"rb 2003",    1, 16'h2003, 8'hA3, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 16'h2003, 8'h00, 0, 0};
    vecs[12] = '{"rb cpu wr",  1, 16'h2200, 8'hC2, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 16'h2200, 8'h00, 0, 0};
    vecs[13] = '{"vid>ldr",    1, 16'h2100, 8'hB1, 1, 16'h2300, 8'hD3, 0, 0, 16'h0000, 8'h00, 0, 16'h2100, 8'h00, 0, 0};
    vecs[14] = '{"ldr after",  0, 16'h0000, 8'h00, 1, 16'h2300, 8'hD3, 0, 0, 16'h0000, 8'h00, 1, 16'h2300, 8'hD3, 1, 0};
    vecs[15] = '{"rb 2300",    1, 16'h2300, 8'hD3, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 16'h2300, 8'h00, 0, 0};
    vecs[16] = '{"idle hold2", 0, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 16'h2300, 8'h00, 0, 0};

    reset = 1'b1;
    video_req = 1'b0; video_addr = '0;
    ldr_req = 1'b0; ldr_addr = '0; ldr_din = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
`ifdef ARB_PERF_EN
    perf_clr = 1'b0;
`endif

    // Reset state
    repeat (2) next_cycle();
    @(negedge clk_sys);
    check("rst video_ack", {31'd0, video_ack}, 32'd0);
    check("rst ldr_ack",   {31'd0, ldr_ack},   32'd0);
    check("rst ram_we",    {31'd0, ram_we},    32'd0);
    check("rst ram_addr",  {16'd0, ram_addr},  32'd0);
    check("rst ram_din",   {24'd0, ram_din},   32'd0);
    check("rst cpu_dout",  {24'd0, cpu_dout},  32'd0);
    check("rst video_data",{24'd0, video_data},32'd0);
    check("rst cpu_wait",  {31'd0, cpu_wait},  32'd0);
    next_cycle();
    reset = 1'b0;

    // Back-to-back video reads
    video_req = 1'b1; video_addr = 16'h2400;
    vid_q.push_back('{cyc_n + 1, 8'h11});
    @(negedge clk_sys);
    check("vid rd0 ram_addr", {16'd0, ram_addr}, 32'h2400);
    next_cycle();
    video_addr = 16'h2401;
    vid_q.push_back('{cyc_n + 1, 8'h22});
    @(negedge clk_sys);
    check("vid rd1 ram_addr", {16'd0, ram_addr}, 32'h2401);
    next_cycle();
    video_req = 1'b0;
    next_cycle();

    // Per-cycle vector table
    for (int i = 0; i < 17; i++) begin
      video_req = vecs[i].vreq; video_addr = vecs[i].vaddr;
      ldr_req = vecs[i].lreq; ldr_addr = vecs[i].laddr; ldr_din = vecs[i].ldin;
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe;
      cpu_addr = vecs[i].caddr; cpu_din = vecs[i].cdin;
      if (vecs[i].vreq) vid_q.push_back('{cyc_n + 1, vecs[i].vexp});
      @(negedge clk_sys);
      check({vecs[i].name, " ram_we"},   {31'd0, ram_we},   {31'd0, vecs[i].e_we});
      check({vecs[i].name, " ram_addr"}, {16'd0, ram_addr}, {16'd0, vecs[i].e_addr});
      check({vecs[i].name, " ldr_ack"},  {31'd0, ldr_ack},  {31'd0, vecs[i].e_lack});
      check({vecs[i].name, " cpu_wait"}, {31'd0, cpu_wait}, {31'd0, vecs[i].e_wait});
      if (vecs[i].e_we) check({vecs[i].name, " ram_din"}, {24'd0, ram_din}, {24'd0, vecs[i].e_din});
      next_cycle();
    end
    next_cycle();

    // CPU read starved by a streaming loader
    ldr_idx = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3C00;
    for (int i = 1; i <= 11; i++) begin
      ldr_req = 1'b1;
      ldr_addr = 16'h2500 + 16'(ldr_idx);
      ldr_din = 8'(ldr_idx);
      if (i == 1) cpu_q.push_back('{cyc_n + 9, 8'h5A});
      if (i == 11) cpu_req = 1'b0;
      @(negedge clk_sys);
      check("starve ldr_ack", {31'd0, ldr_ack}, (i == 9) ? 32'd0 : 32'd1);
      check("starve cpu_wait", {31'd0, cpu_wait}, (i < 10) ? 32'd1 : 32'd0);
      if (i == 9) check("starve cpu ram_addr", {16'd0, ram_addr}, 32'h3C00);
      if (ldr_ack) ldr_idx++;
      next_cycle();
    end
    ldr_req = 1'b0;
    next_cycle();

    // Reset in the capture cycle of a CPU read, then re-issue
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    @(negedge clk_sys);
    check("rstmid grant addr", {16'd0, ram_addr}, 32'h1234);
    check("rstmid grant wait", {31'd0, cpu_wait}, 32'd1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk_sys);
    check("rstmid no capture", {31'd0, cpu_wait}, 32'd1);
    next_cycle();
    reset = 1'b0;
    cpu_q.push_back('{cyc_n + 1, 8'h77});
    @(negedge clk_sys);
    check("rstmid cpu_dout cleared", {24'd0, cpu_dout}, 32'd0);
    check("rstmid regrant wait", {31'd0, cpu_wait}, 32'd1);
    check("rstmid regrant addr", {16'd0, ram_addr}, 32'h1234);
    next_cycle();
    @(negedge clk_sys);
    check("rstmid done wait", {31'd0, cpu_wait}, 32'd0);
    next_cycle();
    cpu_addr = 16'h3C00;
    cpu_q.push_back('{cyc_n + 1, 8'h5A});
    @(negedge clk_sys);
    check("busy single access", {16'd0, ram_addr}, 32'h3C00);
    check("busy next wait", {31'd0, cpu_wait}, 32'd1);
    next_cycle();
    @(negedge clk_sys);
    check("next read wait", {31'd0, cpu_wait}, 32'd0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk_sys);
    check("cpu_dout held", {24'd0, cpu_dout}, 32'h5A);
    next_cycle();

`ifdef ARB_PERF_EN
    // CPU write held off by five video reads
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2700; cpu_din = 8'h01;
    video_addr = 16'h2400;
    for (int i = 0; i < 5; i++) begin
      video_req = 1'b1;
      vid_q.push_back('{cyc_n + 1, 8'h11});
      next_cycle();
    end
    video_req = 1'b0;
    @(negedge clk_sys);
    check("perf cpu_stall 5", {16'd0, cpu_stall_cnt}, 32'd5);
    check("perf cpu write done", {31'd0, cpu_wait}, 32'd0);
    next_cycle();
    cpu_req = 1'b0;
    perf_clr = 1'b1;
    next_cycle();
    perf_clr = 1'b0;
    @(negedge clk_sys);
    check("perf cpu clr", {16'd0, cpu_stall_cnt}, 32'd0);
    check("perf ldr clr", {16'd0, ldr_stall_cnt}, 32'd0);
    next_cycle();

    // Long block saturates both counters
    vid_mon_en = 1'b0;
    video_req = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1;
    ldr_req = 1'b1; ldr_addr = 16'h2800; ldr_din = 8'h02;
    repeat (70000) next_cycle();
    video_req = 1'b0;
    @(negedge clk_sys);
    check("perf cpu sat", {16'd0, cpu_stall_cnt}, 32'hFFFF);
    check("perf ldr sat", {16'd0, ldr_stall_cnt}, 32'hFFFF);
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();
    ldr_req = 1'b0;
    repeat (2) next_cycle();
    vid_mon_en = 1'b1;
`endif

    repeat (2) next_cycle();
    check("video queue drained", vid_q.size(), 32'd0);
    check("cpu queue drained", cpu_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
